adder_pipe_acc: RTL

//  Parametrised, pipelined successor to the single-cycle adder.

---
 rtl/adder_pipe_acc.sv | 118 +++++++++++
 1 files changed

// File: rtl/adder_pipe_acc.sv
// rtl/adder_pipe_acc.sv - pipelined add/sub/accumulate/load unit with valid/ready flow control
module adder_pipe_acc #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             flag
);

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] f_q;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  acc_q;

  logic [WIDTH:0]    raw;
  logic [WIDTH-1:0]  sum;
  logic              cf;
  logic              accept;

  // Ready ripples back from out_ready; a scalar carries it so no vector reads itself.
  always_comb begin
    logic r;
    adv = '0;
    r = ~v_q[STAGES-1] | out_ready;
    adv[STAGES-1] = r;
    for (int k = STAGES - 2; k >= 0; k--) begin
      r = ~v_q[k] | r;
      adv[k] = r;
    end
  end

  assign in_ready = adv[0] & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    raw = '0;
    cf  = 1'b0;
    case (mode)
      MODE_ADD: begin
        raw = {1'b0, a} + {1'b0, b};
        cf  = raw[WIDTH];
      end
      MODE_SUB: begin
        raw = {1'b0, a} - {1'b0, b};
        cf  = (a < b);
      end
      MODE_ACC: begin
        raw = {1'b0, acc_q} + {1'b0, a};
        cf  = raw[WIDTH];
      end
      MODE_LOAD: begin
        raw = {1'b0, a};
        cf  = 1'b0;
      end
      default: begin
        raw = '0;
        cf  = 1'b0;
      end
    endcase
    sum = raw[WIDTH-1:0];
    // Flag keeps the raw carry/borrow even when the value is clamped.
    if (SAT != 0 && cf) begin
      sum = (mode == MODE_SUB) ? '0 : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      f_q   <= '0;
      acc_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      if (accept && mode[1]) begin
        acc_q <= sum;
      end
      if (adv[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          d_q[0] <= sum;
          f_q[0] <= cf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            d_q[k] <= d_q[k-1];
            f_q[k] <= f_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign c         = d_q[STAGES-1];
  assign flag      = f_q[STAGES-1];

endmodule
